// File: rtl/peak_tracker_pkg.sv
// Shared definitions for the peak tracker: FSM state encodings and the
// posen/negen direction decode shared with the slope stage.
package peak_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // Both flags high is illegal upstream and is treated as hold.
  function automatic dir_t decode_dir(input logic posen, input logic negen);
    case ({posen, negen})
      2'b10:   return DIR_UP;
      2'b01:   return DIR_DOWN;
      default: return DIR_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/peak_tracker_sat_counter.sv
// Period counter: loads 1 on clr1, otherwise counts up while en,
// sticking at all-ones so long gaps report a saturated period.
module sat_counter
  import peak_tracker_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr1,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] q,
  output logic                 full
);

  assign full = &q;

  // Load-one has priority over increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr1) begin
      q <= CNT_WIDTH'(1);
    end else if (en && !full) begin
      q <= q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/peak_tracker.sv
// Tracks rising/falling runs of the slope-stage sample stream and, on each
// peak after a full peak/trough/peak history, strobes the latched peak,
// trough, peak-to-trough amplitude and peak-to-peak period.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   ST_IDLE | no direction seen yet since reset
//   ST_RISE | in a rising run, ext holds the running maximum
//   ST_FALL | in a falling run, ext holds the running minimum
module peak_tracker
  import peak_tracker_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] datain,
  input  logic                    posen,
  input  logic                    negen,
  output logic signed [WIDTH-1:0] peak,
  output logic signed [WIDTH-1:0] trough,
  output logic [WIDTH:0]          amplitude,
  output logic [CNT_WIDTH-1:0]    period,
  output logic                    valid,
  output logic                    sat
);

  state_t                  state, state_nxt;
  dir_t                    dir;
  logic signed [WIDTH-1:0] ext, ext_nxt;
  logic signed [WIDTH-1:0] tr_c;
  logic                    have_pk, have_tr;
  logic                    peak_evt, trough_evt;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    cnt_full;
  logic [WIDTH:0]          diff;

  assign dir  = decode_dir(posen, negen);
  // Sign-extended difference; a set MSB means the trough sits above the peak.
  assign diff = {ext[WIDTH-1], ext} - {tr_c[WIDTH-1], tr_c};

  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr1 (peak_evt),
    .en   (have_pk),
    .q    (cnt),
    .full (cnt_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, turning-point events and next running extremum.
  always_comb begin
    state_nxt  = state;
    ext_nxt    = ext;
    peak_evt   = 1'b0;
    trough_evt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dir == DIR_UP) begin
          state_nxt = ST_RISE;
          ext_nxt   = datain;
        end else if (dir == DIR_DOWN) begin
          state_nxt = ST_FALL;
          ext_nxt   = datain;
        end
      end
      ST_RISE: begin
        if (dir == DIR_UP) begin
          ext_nxt = (datain > ext) ? datain : ext;
        end else if (dir == DIR_DOWN) begin
          state_nxt = ST_FALL;
          peak_evt  = 1'b1;
          ext_nxt   = datain;
        end
      end
      ST_FALL: begin
        if (dir == DIR_DOWN) begin
          ext_nxt = (datain < ext) ? datain : ext;
        end else if (dir == DIR_UP) begin
          state_nxt  = ST_RISE;
          trough_evt = 1'b1;
          ext_nxt    = datain;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Extremum tracking, history flags and result registers. The latched peak
  // is ext at the peak event itself, so it goes straight to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext       <= '0;
      tr_c      <= '0;
      have_pk   <= 1'b0;
      have_tr   <= 1'b0;
      peak      <= '0;
      trough    <= '0;
      amplitude <= '0;
      period    <= '0;
      valid     <= 1'b0;
      sat       <= 1'b0;
    end else begin
      ext   <= ext_nxt;
      valid <= 1'b0;
      if (peak_evt) begin
        have_pk <= 1'b1;
        if (have_pk && have_tr) begin
          peak      <= ext;
          trough    <= tr_c;
          period    <= cnt;
          sat       <= cnt_full;
          amplitude <= diff[WIDTH] ? '0 : diff;
          valid     <= 1'b1;
        end
      end
      if (trough_evt) begin
        tr_c    <= ext;
        have_tr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_peak_tracker.sv
// Directed bench for peak_tracker: one instance at default widths and one
// with an 8-bit period counter, both fed the same stimulus.
module tb_peak_tracker;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] datain;
  logic               posen, negen;

  logic signed [15:0] peak16, trough16, peak8, trough8;
  logic [16:0]        amp16, amp8;
  logic [15:0]        per16;
  logic [7:0]         per8;
  logic               v16, s16, v8, s8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  peak_tracker #(.WIDTH(16), .CNT_WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .datain(datain), .posen(posen), .negen(negen),
    .peak(peak16), .trough(trough16), .amplitude(amp16), .period(per16),
    .valid(v16), .sat(s16)
  );

  peak_tracker #(.WIDTH(16), .CNT_WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .datain(datain), .posen(posen), .negen(negen),
    .peak(peak8), .trough(trough8), .amplitude(amp8), .period(per8),
    .valid(v8), .sat(s8)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int d, input logic p, input logic n);
    datain = 16'(d);
    posen  = p;
    negen  = n;
    @(posedge clk);
    #1;
  endtask

  task automatic up(input int d);
    step(d, 1'b1, 1'b0);
  endtask

  task automatic dn(input int d);
    step(d, 1'b0, 1'b1);
  endtask

  task automatic no_valid(input string tag);
    chk({tag, "_valid"}, {30'd0, v16, v8}, 0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_peak16"}, peak16, 0);
    chk({tag, "_trough16"}, trough16, 0);
    chk({tag, "_amp16"}, amp16, 0);
    chk({tag, "_per16"}, per16, 0);
    chk({tag, "_flags"}, {28'd0, v16, s16, v8, s8}, 0);
    chk({tag, "_per8"}, per8, 0);
    chk({tag, "_peak8"}, peak8, 0);
  endtask

  task automatic expect_result(input string tag, input int pk, input int tr,
                               input int amp, input int p16, input int sa16,
                               input int p8, input int sa8);
    chk({tag, "_valid16"}, v16, 1);
    chk({tag, "_valid8"}, v8, 1);
    chk({tag, "_peak"}, peak16, pk);
    chk({tag, "_trough"}, trough16, tr);
    chk({tag, "_amp"}, amp16, amp);
    chk({tag, "_period16"}, per16, p16);
    chk({tag, "_sat16"}, s16, sa16);
    chk({tag, "_peak8"}, peak8, pk);
    chk({tag, "_amp8"}, amp8, amp);
    chk({tag, "_period8"}, per8, p8);
    chk({tag, "_sat8"}, s8, sa8);
  endtask

  initial begin
    reset  = 1'b1;
    datain = '0;
    posen  = 1'b0;
    negen  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    reset = 1'b0;

    // Idle with flags low.
    for (int i = 0; i < 20; i++) begin
      step(0, 1'b0, 1'b0);
      no_valid("idle");
    end
    all_zero("idle_end");

    // Ramp: rise 0..100, fall 90..-50, rise -40..100, fall.
    for (int v = 0; v <= 100; v += 10) begin
      up(v);
      no_valid("rise1");
    end
    dn(90);
    no_valid("first_peak");
    for (int v = 80; v >= -50; v -= 10) begin
      dn(v);
      no_valid("fall1");
    end
    for (int v = -40; v <= 100; v += 10) begin
      up(v);
      no_valid("rise2");
    end
    dn(90);
    expect_result("ramp", 100, -50, 150, 30, 0, 30, 0);

    // Strobe lasts one cycle and results hold afterwards.
    dn(80);
    no_valid("strobe_len");
    chk("hold_peak", peak16, 100);
    chk("hold_period", per16, 30);
    for (int v = 70; v >= 0; v -= 10) begin
      dn(v);
      no_valid("fall2");
    end

    // Illegal both-flags inside a rising run must not move state or ext.
    up(10);
    up(20);
    up(30);
    for (int i = 0; i < 5; i++) begin
      step((i % 2 == 0) ? 500 : -500, 1'b1, 1'b1);
      no_valid("both_flags");
    end
    dn(20);
    expect_result("hold", 30, 0, 30, 18, 0, 18, 0);

    // Trough above peak clamps amplitude to zero.
    dn(10);
    up(5);
    dn(0);
    expect_result("clamp", 5, 10, 0, 3, 0, 3, 0);

    // Full-scale swing.
    dn(-32768);
    up(0);
    up(32767);
    dn(0);
    expect_result("extreme", 32767, -32768, 65535, 4, 0, 4, 0);

    // Long gap: 8-bit counter saturates, 16-bit does not.
    up(1);
    for (int i = 0; i < 300; i++) begin
      step(1, 1'b0, 1'b0);
      if (i % 50 == 0) no_valid("long_gap");
    end
    dn(0);
    expect_result("sat", 1, 0, 1, 302, 0, 255, 1);
    up(1);
    up(2);
    dn(0);
    expect_result("after_sat", 2, 0, 2, 3, 0, 3, 0);

    // Reset between a trough and the next peak discards history.
    up(1);
    no_valid("pre_reset_trough");
    reset = 1'b1;
    step(0, 1'b0, 1'b0);
    reset = 1'b0;
    all_zero("mid_reset");
    up(10);
    dn(5);
    no_valid("post_reset_peak");
    up(6);
    no_valid("post_reset_trough");
    up(9);
    dn(0);
    expect_result("post_reset", 9, 5, 4, 3, 0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
